// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding and the opcode values the ALU understands.
// Opcodes are listed for reference only; the arbiter never decodes them.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int OPW = 3;
   localparam int STW = 4;

   localparam logic [OPW-1:0] OP_ADD = 3'b000;
   localparam logic [OPW-1:0] OP_XOR = 3'b001;
   localparam logic [OPW-1:0] OP_AND = 3'b010;
   localparam logic [OPW-1:0] OP_OR  = 3'b011;
   localparam logic [OPW-1:0] OP_NOR = 3'b100;
   localparam logic [OPW-1:0] OP_SL  = 3'b101;
   localparam logic [OPW-1:0] OP_SR  = 3'b110;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant picker: a lone valid wins, a tie goes to the one not granted last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arb2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic last_i,     // id granted most recently
   output logic gnt_o       // 0 = requester 0, 1 = requester 1
);

   // Tie: alternate away from last winner; otherwise pick whichever is valid.
   always_comb begin
      gnt_o = 1'b0;
      if (valid0_i && valid1_i) begin
         gnt_o = ~last_i;
      end else begin
         gnt_o = valid1_i;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Latency: accept edge N, result captured at N+1, response valid after N+1; one op per 3 cycles.
// Backpressure: no new accept until the owner takes its response; ALU_ARB_FIXED_PRIO_EN makes req0 win ties.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   input  logic            req1_valid,
   output logic            req0_ready,
   output logic            req1_ready,
   input  logic [DW-1:0]   req0_a,
   input  logic [DW-1:0]   req0_b,
   input  logic [DW-1:0]   req1_a,
   input  logic [DW-1:0]   req1_b,
   input  logic            req0_cin,
   input  logic            req0_sub,
   input  logic            req1_cin,
   input  logic            req1_sub,
   input  logic [OPW-1:0]  req0_op,
   input  logic [OPW-1:0]  req1_op,
   output logic            rsp0_valid,
   output logic            rsp1_valid,
   input  logic            rsp0_ready,
   input  logic            rsp1_ready,
   output logic [DW-1:0]   rsp_result,
   output logic [STW-1:0]  rsp_status,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic            alu_cin,
   output logic            alu_sub,
   output logic [OPW-1:0]  alu_op,
   input  logic [DW-1:0]   alu_result,
   input  logic [STW-1:0]  alu_status
);

   state_e          state_q;
   logic [DW-1:0]   a_q, b_q, res_q;
   logic            cin_q, sub_q, id_q;
   logic [OPW-1:0]  op_q;
   logic [STW-1:0]  stat_q;
   logic            rsp0_vld_q, rsp1_vld_q;
   logic            ptr;
   logic            gnt;
   logic            accept;
   logic            owner_rdy;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Pretend requester 1 always won last so requester 0 takes every tie.
   assign ptr = 1'b1;
`else
   logic last_q;
   assign ptr = last_q;
`endif

   rr_arb2 u_rr_arb2 (
      .valid0_i (req0_valid),
      .valid1_i (req1_valid),
      .last_i   (ptr),
      .gnt_o    (gnt)
   );

   // Ready only in IDLE, only to the granted requester, and never while reset is held.
   assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !gnt;
   assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && gnt;
   assign accept     = req0_ready || req1_ready;
   assign owner_rdy  = id_q ? rsp1_ready : rsp0_ready;

   // ALU is always fed from the operand registers, never straight from requesters.
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_cin    = cin_q;
   assign alu_sub    = sub_q;
   assign alu_op     = op_q;
   assign rsp_result = res_q;
   assign rsp_status = stat_q;
   assign rsp0_valid = rsp0_vld_q;
   assign rsp1_valid = rsp1_vld_q;

   // Arbiter FSM with registered operands, result and response valids.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         cin_q      <= 1'b0;
         sub_q      <= 1'b0;
         op_q       <= '0;
         id_q       <= 1'b0;
         res_q      <= '0;
         stat_q     <= '0;
         rsp0_vld_q <= 1'b0;
         rsp1_vld_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_q     <= 1'b1;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= gnt ? req1_a   : req0_a;
                  b_q     <= gnt ? req1_b   : req0_b;
                  cin_q   <= gnt ? req1_cin : req0_cin;
                  sub_q   <= gnt ? req1_sub : req0_sub;
                  op_q    <= gnt ? req1_op  : req0_op;
                  id_q    <= gnt;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last_q  <= gnt;
`endif
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q      <= alu_result;
               stat_q     <= alu_status;
               rsp0_vld_q <= ~id_q;
               rsp1_vld_q <= id_q;
               state_q    <= RESP;
            end
            RESP: begin
               if (owner_rdy) begin
                  rsp0_vld_q <= 1'b0;
                  rsp1_vld_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: acts as the ALU, keeps a transaction-level model of the arbiter,
// and checks every DUT output every cycle plus hand-computed results for directed cases.
// Honours ALU_ARB_FIXED_PRIO_EN for the tie-break rule.
module tb_alu_arbiter;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req0_valid, req1_valid, req0_ready, req1_ready;
   logic [DW-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic            req0_cin, req0_sub, req1_cin, req1_sub;
   logic [2:0]      req0_op, req1_op;
   logic            rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [DW-1:0]   rsp_result;
   logic [3:0]      rsp_status;
   logic [DW-1:0]   alu_a, alu_b, alu_result;
   logic            alu_cin, alu_sub;
   logic [2:0]      alu_op;
   logic [3:0]      alu_status;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Reference ALU: returns {status, result}; status = {zero, neg, carry, op==7}.
   function automatic logic [DW+3:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic cin, input logic sub, input logic [2:0] op);
      logic [DW:0]   s;
      logic [DW-1:0] r;
      logic          c;
      c = 1'b0;
      s = '0;
      case (op)
         3'b000: begin
            s = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{DW{1'b0}}, cin};
            r = s[DW-1:0];
            c = s[DW];
         end
         3'b001: r = a ^ b;
         3'b010: r = a & b;
         3'b011: r = a | b;
         3'b100: r = ~(a | b);
         3'b101: r = a << b[4:0];
         3'b110: r = a >> b[4:0];
         default: r = ~a ^ b;
      endcase
      return {(r == '0), r[DW-1], c, (op == 3'b111), r};
   endfunction

   assign {alu_status, alu_result} = alu_fn(alu_a, alu_b, alu_cin, alu_sub, alu_op);

   alu_arbiter #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_cin(req0_cin), .req0_sub(req0_sub), .req1_cin(req1_cin), .req1_sub(req1_sub),
      .req0_op(req0_op), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_status(rsp_status),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sub(alu_sub), .alu_op(alu_op),
      .alu_result(alu_result), .alu_status(alu_status)
   );

   // Transaction model: one in-flight op, its age in cycles since acceptance.
   bit            m_busy;
   int            m_age;
   bit            m_owner;
   bit            m_last;
   logic [DW-1:0] m_a, m_b;
   logic          m_cin, m_sub;
   logic [2:0]    m_op;

   // Values sampled at the last compare point, for directed checks.
   logic          s_rdy0, s_rdy1, s_rv0, s_rv1, s_any;
   logic [DW-1:0] s_res;
   logic [2:0]    s_aluop;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
      m_a = '0; m_b = '0; m_cin = 0; m_sub = 0; m_op = '0;
   endtask

   // One clock: compare on the falling edge, advance the model on the rising edge.
   task automatic cycle();
      logic          g, e_r0, e_r1, e_v0, e_v1;
      logic [DW+3:0] e;
      @(negedge clk);
      if (!rst_n) model_reset();
      e_r0 = 0; e_r1 = 0; g = 0;
      if (rst_n && !m_busy && (req0_valid || req1_valid)) begin
         if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            g = 1'b0;
`else
            g = ~m_last;
`endif
         end else begin
            g = req1_valid;
         end
         e_r0 = !g;
         e_r1 = g;
      end
      e_v0 = m_busy && (m_age >= 2) && !m_owner;
      e_v1 = m_busy && (m_age >= 2) && m_owner;
      e    = alu_fn(m_a, m_b, m_cin, m_sub, m_op);
      chk("req0_ready", 64'(req0_ready), 64'(e_r0));
      chk("req1_ready", 64'(req1_ready), 64'(e_r1));
      chk("rsp0_valid", 64'(rsp0_valid), 64'(e_v0));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(e_v1));
      chk("alu_a", 64'(alu_a), 64'(m_a));
      chk("alu_b", 64'(alu_b), 64'(m_b));
      chk("alu_ctl", 64'({alu_cin, alu_sub, alu_op}), 64'({m_cin, m_sub, m_op}));
      if (e_v0 || e_v1) begin
         chk("rsp_result", 64'(rsp_result), 64'(e[DW-1:0]));
         chk("rsp_status", 64'(rsp_status), 64'(e[DW+3:DW]));
      end
      if (!rst_n) chk("rsp_reset", 64'({rsp_result, rsp_status}), 64'(0));
      s_rdy0 = req0_ready; s_rdy1 = req1_ready; s_rv0 = rsp0_valid; s_rv1 = rsp1_valid;
      s_res = rsp_result; s_aluop = alu_op;
      s_any = |{req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_status,
                alu_a, alu_b, alu_cin, alu_sub, alu_op};
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (m_busy) begin
         if (m_age >= 2) begin
            if (m_owner ? rsp1_ready : rsp0_ready) m_busy = 0;
         end else begin
            m_age = m_age + 1;
         end
      end else if (e_r0 || e_r1) begin
         m_busy = 1; m_age = 1; m_owner = e_r1; m_last = e_r1;
         m_a   = e_r1 ? req1_a   : req0_a;
         m_b   = e_r1 ? req1_b   : req0_b;
         m_cin = e_r1 ? req1_cin : req0_cin;
         m_sub = e_r1 ? req1_sub : req0_sub;
         m_op  = e_r1 ? req1_op  : req0_op;
      end
      #1;
   endtask

   task automatic drive(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic cin, input logic sub, input logic [2:0] op);
      if (id == 0) begin
         req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_op = op;
      end else begin
         req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_op = op;
      end
   endtask

   // Single request from accept to response handshake, with bounded waits.
   task automatic run_one(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic cin, input logic [2:0] op, input logic [DW-1:0] exp,
                          input string nm);
      bit seen;
      drive(id, a, b, cin, 1'b0, op);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         cycle();
         seen = (id == 1) ? s_rdy1 : s_rdy0;
      end
      chk({nm, "_accept"}, 64'(seen), 64'(1));
      req0_valid = 0; req1_valid = 0;
      cycle();
      chk({nm, "_exec_op"}, 64'(s_aluop), 64'(op));
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         cycle();
         seen = (id == 1) ? s_rv1 : s_rv0;
      end
      chk({nm, "_rsp_vld"}, 64'(seen), 64'(1));
      chk({nm, "_result"}, 64'(s_res), 64'(exp));
      chk({nm, "_other_vld"}, 64'((id == 1) ? s_rv0 : s_rv1), 64'(0));
      rsp0_ready = (id == 0); rsp1_ready = (id == 1);
      cycle();
      rsp0_ready = 0; rsp1_ready = 0;
      cycle();
   endtask

   initial begin
      rst_n = 0;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      req0_cin = 0; req0_sub = 0; req1_cin = 0; req1_sub = 0; req0_op = '0; req1_op = '0;
      model_reset();
      #1;
      cycle();
      // Reset must silence ready even with requests pending.
      req0_valid = 1; req1_valid = 1;
      cycle();
      chk("reset_all_zero", 64'(s_any), 64'(0));
      req0_valid = 0; req1_valid = 0;
      rst_n = 1;
      cycle();

      // Exact latency on a lone req0 ADD 5+10.
      drive(0, 32'd5, 32'd10, 1'b0, 1'b0, 3'b000);
      cycle();
      chk("add0_accept", 64'(s_rdy0), 64'(1));
      req0_valid = 0;
      cycle();
      chk("add0_exec_op", 64'(s_aluop), 64'(0));
      chk("add0_exec_novld", 64'(s_rv0), 64'(0));
      cycle();
      chk("add0_rsp_vld", 64'(s_rv0), 64'(1));
      chk("add0_result", 64'(s_res), 64'(15));
      rsp0_ready = 1; cycle(); rsp0_ready = 0; cycle();

      run_one(1, 32'd6, 32'd5, 1'b1, 3'b000, 32'd12, "add1");
      run_one(0, 32'h1234, 32'h00ff, 1'b0, 3'b111, ~32'h1234 ^ 32'h00ff, "op7");

      // Tie straight after reset: req0 first, then req1, then req0 again.
      rst_n = 0; cycle(); rst_n = 1; cycle();
      drive(0, 32'd5, 32'd9, 1'b0, 1'b0, 3'b001);
      drive(1, 32'd6, 32'd10, 1'b0, 1'b0, 3'b010);
      cycle();
      chk("tie_first_r0", 64'(s_rdy0), 64'(1));
      chk("tie_first_r1", 64'(s_rdy1), 64'(0));
      req0_valid = 0;
      cycle();
      chk("tie_exec_r1", 64'(s_rdy1), 64'(0));
      cycle();
      chk("tie_xor_vld", 64'(s_rv0), 64'(1));
      chk("tie_xor_res", 64'(s_res), 64'(12));
      rsp0_ready = 1; cycle(); rsp0_ready = 0;
      cycle();
      chk("tie_second_r1", 64'(s_rdy1), 64'(1));
      req1_valid = 0;
      cycle(); cycle();
      chk("tie_and_vld", 64'(s_rv1), 64'(1));
      chk("tie_and_res", 64'(s_res), 64'(2));
      rsp1_ready = 1; cycle(); rsp1_ready = 0;
      drive(0, 32'd1, 32'd1, 1'b0, 1'b0, 3'b000);
      drive(1, 32'd2, 32'd2, 1'b0, 1'b0, 3'b000);
      cycle();
      chk("tie_third_r0", 64'(s_rdy0), 64'(1));
      req0_valid = 0; req1_valid = 0;
      rsp0_ready = 1; cycle(); cycle(); cycle(); rsp0_ready = 0; cycle();

      // Owner stalls 4 cycles: response held, no new accept despite pending requests.
      drive(0, 32'd3, 32'd4, 1'b0, 1'b0, 3'b101);
      cycle(); cycle();
      drive(1, 32'd9, 32'd9, 1'b0, 1'b0, 3'b000);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("stall_vld", 64'(s_rv0), 64'(1));
         chk("stall_res", 64'(s_res), 64'(48));
         chk("stall_rdy", 64'({s_rdy0, s_rdy1}), 64'(0));
      end
      req0_valid = 0; req1_valid = 0;
      rsp0_ready = 1; cycle(); rsp0_ready = 0; cycle();

      // Reset during EXEC abandons the op.
      drive(0, 32'd7, 32'd11, 1'b0, 1'b0, 3'b011);
      cycle();
      chk("rstx_accept", 64'(s_rdy0), 64'(1));
      req0_valid = 0;
      rst_n = 0;
      cycle();
      chk("rstx_all_zero", 64'(s_any), 64'(0));
      rst_n = 1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("rstx_no_rsp", 64'(s_rv0), 64'(0));
      end
      run_one(0, 32'd1, 32'd2, 1'b0, 3'b000, 32'd3, "after_rst");

      // Random traffic, random consumer readiness, rare reset pulses.
      for (int n = 0; n < 2000; n++) begin
         rst_n      = ($urandom_range(0, 199) != 0);
         req0_valid = ($urandom_range(0, 9) < 6);
         req1_valid = ($urandom_range(0, 9) < 6);
         req0_a = $urandom(); req0_b = $urandom(); req1_a = $urandom(); req1_b = $urandom();
         if ($urandom_range(0, 1) == 0) req0_b = 32'($urandom_range(0, 40));
         req0_cin = 1'($urandom()); req0_sub = 1'($urandom());
         req1_cin = 1'($urandom()); req1_sub = 1'($urandom());
         req0_op = 3'($urandom()); req1_op = 3'($urandom());
         rsp0_ready = ($urandom_range(0, 1) == 1);
         rsp1_ready = ($urandom_range(0, 1) == 1);
         cycle();
      end
      rst_n = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
      for (int k = 0; k < 4; k++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width of operands and result.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester i has an operation pending.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1  arbiter accepts requester i this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DW  operands A and B.
REQ-007 SHALL have ports req0_cin, req0_sub, req1_cin, req1_sub  input  1  carry-in and subtract control.
REQ-008 SHALL have ports req0_op, req1_op  input  3  ALU opcode.
REQ-009 SHALL have ports rsp0_valid, rsp1_valid  output  1  result pending for requester i.
REQ-010 SHALL have ports rsp0_ready, rsp1_ready  input  1  requester i consumes its result.
REQ-011 SHALL have ports rsp_result  output  DW and rsp_status  output  4, shared by both responses.
REQ-012 SHALL have ports alu_a, alu_b  output  DW;  alu_cin, alu_sub  output  1;  alu_op  output  3, driving the shared ALU.
REQ-013 SHALL have ports alu_result  input  DW and alu_status  input  4, combinational ALU outputs.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 IDLE: grant = one valid requester; req<g>_ready high combinationally for the granted requester only; valid&ready latches a, b, cin, sub, op into operand registers, stores grant id, goes to EXEC.
REQ-016 EXEC: operand registers drive alu_* for exactly one cycle; alu_result/alu_status captured at the clock edge ending EXEC; go to RESP.
REQ-017 RESP: rsp<id>_valid high, other rsp valid low; rsp_result/rsp_status stable until rsp<id>_ready; on handshake go to IDLE.
REQ-018 Latency: request accepted at edge N gives rsp valid from edge N+2; maximum throughput one op per 3 cycles; no bypass from RESP to a new accept.
REQ-019 Round-robin: when both valid in IDLE, grant the requester not granted last; single valid requester granted regardless of pointer.
REQ-020 Pointer updates only on an accepted request.
REQ-021 Opcode, cin, sub forwarded unmodified, including unused opcode 3'b111; no decode of ALU function.
REQ-022 alu_* outputs SHALL hold operand-register values in all states (no glitching to requester inputs).
REQ-023 Requester deasserting valid before grant SHALL NOT be accepted; no request dropped once accepted.
REQ-024 rsp ready on the non-owning requester SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, operand/result registers to 0, all ready/valid outputs to 0, pointer to requester 1 (so requester 0 wins the first tie).
REQ-026 Reset during EXEC or RESP SHALL abandon the transaction; no response is ever issued for it.

Configuration
REQ-027 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties, pointer logic removed.
REQ-028 Macro undefined: round-robin per REQ-019/020.

Structure
REQ-029 Package alu_arb_pkg SHALL hold the FSM state enum and opcode constants ADD=000, XOR=001, AND=010, OR=011, NOR=100, SL=101, SR=110.
REQ-030 Two-way grant picker SHALL be sub-module rr_arb2 (inputs two valids, pointer; output grant id).

Verification
REQ-031 req0 ADD a=5 b=10 cin=0 -> alu_op=000 in EXEC, rsp0_valid at N+2 with rsp_result=15.
REQ-032 req1 ADD a=6 b=5 cin=1 -> rsp1_valid, rsp_result=12; rsp0_valid stays 0.
REQ-033 Both valid same cycle after reset, req0 XOR 5,9 and req1 AND 6,10 -> req0 first result 12, then req1 result 2; next tie grants req0 (round-robin) or req0 (fixed).
REQ-034 rsp0_ready low 4 cycles in RESP -> rsp0_valid and rsp_result held constant, req ready outputs low throughout.
REQ-035 rst_n pulsed low during EXEC of req0 OR 7,11 -> all outputs 0, no rsp0_valid afterwards, next request served normally.
